ftdi_tx_mux: RTL and testbench

Round-robin packet arbiter that shares the single FPGA→FTDI byte stream between up to 16 producer channels, e.g. ADC sample streams and command responses. Each granted burst is prefixed with a one-byte header that identifies the source channel, so the host can demultiplex the stream. The block sits in the FTDI clock domain. Its output stream connects directly to the FT245 sync bridge TX stream input (i_tx_data/i_tx_valid/o_tx_ready).

---
 rtl/ftdi_mux_pkg.sv | 13 +
 rtl/ftdi_tx_mux_rr_pick.sv | 32 +++
 rtl/ftdi_tx_mux.sv | 131 +++++++++++++
 tb/tb_ftdi_tx_mux.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ftdi_mux_pkg.sv
// Shared types and header constants for the FTDI TX multiplexer and its arbiters.
package ftdi_mux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    localparam logic [7:0] HDR_MARK    = 8'h80;
    localparam int         HDR_SOP_BIT = 6;

endpackage

// File: rtl/ftdi_tx_mux_rr_pick.sv
// Rotating-priority encoder: finds the first set request at or above i_ptr, wrapping at N.
// Purely combinational; o_idx is 0 when nothing is requested.
module rr_pick
    import ftdi_mux_pkg::*;
#(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_ptr,
    output logic         o_found,
    output logic [W-1:0] o_idx
);

    function automatic int wrap_idx(input int base, input int ofs);
        int s;
        s = base + ofs;
        return (s >= N) ? s - N : s;
    endfunction

    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        for (int i = 0; i < N; i++) begin
            if (!o_found && i_req[wrap_idx(int'(i_ptr), i)]) begin
                o_found = 1'b1;
                o_idx   = W'(wrap_idx(int'(i_ptr), i));
            end
        end
    end

endmodule

// File: rtl/ftdi_tx_mux.sv
// Round-robin burst arbiter merging NCH byte streams into one FTDI TX stream,
// prefixing each burst with a header carrying the channel and start-of-packet flag.
module ftdi_tx_mux
    import ftdi_mux_pkg::*;
#(
    parameter int NCH          = 4,
    parameter int MAX_BURST    = 64,
    parameter int IDLE_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [8*NCH-1:0] i_ch_data,
    input  logic [NCH-1:0]   i_ch_valid,
    input  logic [NCH-1:0]   i_ch_last,
    output logic [NCH-1:0]   o_ch_ready,
    output logic [7:0]       o_data,
    output logic             o_valid,
    input  logic             i_ready
);

    localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam int IW = $clog2(IDLE_TIMEOUT + 1);

    localparam logic [GW-1:0] LAST_CH   = GW'(NCH - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(MAX_BURST - 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [GW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]    g_q, g_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [IW-1:0]    idle_cnt_q, idle_cnt_d;
    logic [NCH-1:0]   midpkt_q, midpkt_d;

    logic             pick_found;
    logic [GW-1:0]    pick_idx;
    logic [7:0]       hdr;
    logic [7:0]       sel_data;
    logic             sel_vld;
    logic             sel_last;

    rr_pick #(.N(NCH), .W(GW)) u_pick (
        .i_req   (i_ch_valid),
        .i_ptr   (rr_ptr_q),
        .o_found (pick_found),
        .o_idx   (pick_idx)
    );

    assign sel_data = i_ch_data[8*g_q +: 8];
    assign sel_vld  = i_ch_valid[g_q];
    assign sel_last = i_ch_last[g_q];

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        g_d        = g_q;
        cnt_d      = cnt_q;
        idle_cnt_d = idle_cnt_q;
        midpkt_d   = midpkt_q;
        o_valid    = 1'b0;
        o_data     = 8'h00;
        o_ch_ready = '0;

        hdr              = HDR_MARK;
        hdr[HDR_SOP_BIT] = ~midpkt_q[g_q];
        hdr[3:0]         = 4'(g_q);

        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    g_d      = pick_idx;
                    rr_ptr_d = (pick_idx == LAST_CH) ? '0 : pick_idx + 1'b1;
                    state_d  = ST_HDR;
                end
            end
            ST_HDR: begin
                o_valid = 1'b1;
                o_data  = hdr;
                if (i_ready) begin
                    cnt_d      = '0;
                    idle_cnt_d = '0;
                    state_d    = ST_DATA;
                end
            end
            ST_DATA: begin
                o_valid         = sel_vld;
                o_data          = sel_data;
                o_ch_ready[g_q] = i_ready;
                if (sel_vld && i_ready) begin
                    // last takes precedence over the burst limit so the packet closes cleanly
                    if (sel_last) begin
                        midpkt_d[g_q] = 1'b0;
                        state_d       = ST_IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        midpkt_d[g_q] = 1'b1;
                        state_d       = ST_IDLE;
                    end else begin
                        cnt_d      = cnt_q + 1'b1;
                        idle_cnt_d = '0;
                    end
                end else if (idle_cnt_q == IDLE_LAST) begin
                    midpkt_d[g_q] = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            g_q        <= '0;
            cnt_q      <= '0;
            idle_cnt_q <= '0;
            midpkt_q   <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            g_q        <= g_d;
            cnt_q      <= cnt_d;
            idle_cnt_q <= idle_cnt_d;
            midpkt_q   <= midpkt_d;
        end
    end

endmodule

// File: tb/tb_ftdi_tx_mux.sv
// Bench for ftdi_tx_mux: cycle vectors, directed multi-cycle scenarios, and a
// randomized run against a behavioural model of the arbitration rules.
module tb_ftdi_tx_mux;

    localparam int NCH = 4;
    localparam int MB  = 4;
    localparam int IT  = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_ch_data;
    logic [3:0]  i_ch_valid;
    logic [3:0]  i_ch_last;
    logic [3:0]  o_ch_ready;
    logic [7:0]  o_data;
    logic        o_valid;
    logic        i_ready;

    ftdi_tx_mux #(.NCH(NCH), .MAX_BURST(MB), .IDLE_TIMEOUT(IT)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_ch_data  (i_ch_data),
        .i_ch_valid (i_ch_valid),
        .i_ch_last  (i_ch_last),
        .o_ch_ready (o_ch_ready),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .i_ready    (i_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  v;
        logic [3:0]  l;
        logic [31:0] d;
        logic        rdy;
        logic        ev;
        logic [7:0]  ed;
        logic [3:0]  er;
    } vec_t;

    vec_t tbl [16];

    int n_vec = 0;
    int n_err = 0;

    // per-channel sources: {last, byte}
    logic [8:0] src_q [NCH][$];
    bit         en [NCH];
    int         hold [NCH];
    logic [7:0] out_q [$];
    int         gap_q [$];
    int         gap_run;
    logic [7:0] exp_s [$];
    bit         model_on;

    // reference model: owning channel (-1 = none), header still owed, bytes and quiet cycles in burst
    int m_own, m_rr, m_bytes, m_quiet;
    bit m_hdr;
    bit m_mid [NCH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_own = -1; m_rr = 0; m_hdr = 1'b0; m_bytes = 0; m_quiet = 0;
        for (int k = 0; k < NCH; k++) m_mid[k] = 1'b0;
    endtask

    task automatic model_cycle();
        logic       ev;
        logic [7:0] ed;
        logic [3:0] er;
        ev = 1'b0; ed = 8'h00; er = 4'h0;
        if (m_own < 0) begin
            for (int i = 0; i < NCH; i++) begin
                int c;
                c = (m_rr + i) % NCH;
                if (m_own < 0 && i_ch_valid[c]) begin
                    m_own = c;
                    m_rr  = (c + 1) % NCH;
                    m_hdr = 1'b1;
                end
            end
        end else if (m_hdr) begin
            ev = 1'b1;
            ed = 8'h80 | (m_mid[m_own] ? 8'h00 : 8'h40) | 8'(m_own);
            if (i_ready) begin
                m_hdr = 1'b0; m_bytes = 0; m_quiet = 0;
            end
        end else begin
            ev = i_ch_valid[m_own];
            ed = i_ch_data[8*m_own +: 8];
            er = i_ready ? 4'(1 << m_own) : 4'h0;
            if (i_ch_valid[m_own] && i_ready) begin
                m_bytes++;
                m_quiet = 0;
                if (i_ch_last[m_own]) begin
                    m_mid[m_own] = 1'b0; m_own = -1;
                end else if (m_bytes == MB) begin
                    m_mid[m_own] = 1'b1; m_own = -1;
                end
            end else begin
                m_quiet++;
                if (m_quiet == IT) begin
                    m_mid[m_own] = 1'b1; m_own = -1;
                end
            end
        end
        check("rand_valid", 32'(o_valid), 32'(ev));
        check("rand_data", 32'(o_data), 32'(ed));
        check("rand_ch_ready", 32'(o_ch_ready), 32'(er));
    endtask

    // One clock: drive at negedge, observe #1 later, record the transfers due at the next posedge.
    task automatic step(input bit r, input bit rdy);
        @(negedge clk);
        rst     = r;
        i_ready = rdy;
        for (int k = 0; k < NCH; k++) begin
            if (en[k] && src_q[k].size() > 0) begin
                i_ch_valid[k]       = 1'b1;
                i_ch_data[8*k +: 8] = src_q[k][0][7:0];
                i_ch_last[k]        = src_q[k][0][8];
            end else begin
                i_ch_valid[k]       = 1'b0;
                i_ch_data[8*k +: 8] = 8'($urandom);
                i_ch_last[k]        = 1'($urandom);
            end
        end
        #1;
        if (model_on) model_cycle();
        if (!r) begin
            if (o_valid && i_ready) begin
                out_q.push_back(o_data);
                gap_q.push_back(gap_run);
            end
            gap_run = o_valid ? 0 : gap_run + 1;
            for (int k = 0; k < NCH; k++)
                if (i_ch_valid[k] && o_ch_ready[k]) void'(src_q[k].pop_front());
        end
    endtask

    task automatic do_reset();
        for (int k = 0; k < NCH; k++) begin
            src_q[k].delete();
            en[k]   = 1'b1;
            hold[k] = 0;
        end
        out_q.delete();
        gap_q.delete();
        exp_s.delete();
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        gap_run = 0;
    endtask

    task automatic run_until(input int n, input string name);
        int budget;
        budget = 200;
        while (out_q.size() < n && budget > 0) begin
            step(1'b0, 1'b1);
            budget--;
        end
        if (out_q.size() < n) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_stall: got %0d bytes, required %0d", name, out_q.size(), n);
        end
    endtask

    task automatic check_stream(input string name);
        check({name, "_len"}, 32'(out_q.size()), 32'(exp_s.size()));
        for (int i = 0; i < exp_s.size() && i < out_q.size(); i++)
            check($sformatf("%s_b%0d", name, i), 32'(out_q[i]), 32'(exp_s[i]));
    endtask

    initial begin
        rst = 1'b1; i_ready = 1'b0; i_ch_valid = '0; i_ch_last = '0; i_ch_data = '0;
        model_on = 1'b0; gap_run = 0;

        //          v     l     data          rdy   ev    ed     er
        tbl[0]  = '{4'h0, 4'h0, 32'h00000000, 1'b1, 1'b0, 8'h00, 4'h0};
        tbl[1]  = '{4'h4, 4'h0, 32'h00110000, 1'b1, 1'b0, 8'h00, 4'h0};
        tbl[2]  = '{4'h4, 4'h0, 32'h00110000, 1'b1, 1'b1, 8'hC2, 4'h0};
        tbl[3]  = '{4'h4, 4'h0, 32'h00110000, 1'b1, 1'b1, 8'h11, 4'h4};
        tbl[4]  = '{4'h4, 4'h0, 32'h00220000, 1'b1, 1'b1, 8'h22, 4'h4};
        tbl[5]  = '{4'h4, 4'h4, 32'h00330000, 1'b1, 1'b1, 8'h33, 4'h4};
        tbl[6]  = '{4'h0, 4'h0, 32'h00000000, 1'b1, 1'b0, 8'h00, 4'h0};
        tbl[7]  = '{4'h4, 4'h0, 32'h00AA0000, 1'b1, 1'b0, 8'h00, 4'h0};
        tbl[8]  = '{4'h4, 4'h0, 32'h00AA0000, 1'b0, 1'b1, 8'hC2, 4'h0};
        tbl[9]  = '{4'h4, 4'h0, 32'h00AA0000, 1'b0, 1'b1, 8'hC2, 4'h0};
        tbl[10] = '{4'h4, 4'h0, 32'h00AA0000, 1'b1, 1'b1, 8'hC2, 4'h0};
        tbl[11] = '{4'h4, 4'h0, 32'h00AA0000, 1'b0, 1'b1, 8'hAA, 4'h0};
        tbl[12] = '{4'h4, 4'h0, 32'h00AA0000, 1'b0, 1'b1, 8'hAA, 4'h0};
        tbl[13] = '{4'h4, 4'h0, 32'h00AA0000, 1'b1, 1'b1, 8'hAA, 4'h4};
        tbl[14] = '{4'h4, 4'h4, 32'h00BB0000, 1'b1, 1'b1, 8'hBB, 4'h4};
        tbl[15] = '{4'h0, 4'h0, 32'h00000000, 1'b1, 1'b0, 8'h00, 4'h0};

        do_reset();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            rst        = 1'b0;
            i_ch_valid = tbl[i].v;
            i_ch_last  = tbl[i].l;
            i_ch_data  = tbl[i].d;
            i_ready    = tbl[i].rdy;
            #1;
            check($sformatf("tbl%0d_valid", i), 32'(o_valid), 32'(tbl[i].ev));
            check($sformatf("tbl%0d_data", i), 32'(o_data), 32'(tbl[i].ed));
            check($sformatf("tbl%0d_ch_ready", i), 32'(o_ch_ready), 32'(tbl[i].er));
        end

        // round robin between ch0 and ch3, one-byte packets
        do_reset();
        for (int i = 0; i < 4; i++) begin
            src_q[0].push_back(9'(256 + 'hA0 + i));
            src_q[3].push_back(9'(256 + 'hB0 + i));
            exp_s.push_back(8'hC0); exp_s.push_back(8'(8'hA0 + i));
            exp_s.push_back(8'hC3); exp_s.push_back(8'(8'hB0 + i));
        end
        run_until(16, "rr");
        check_stream("rr");

        // burst limit splits a 6-byte packet; a following packet starts fresh
        do_reset();
        for (int i = 0; i < 6; i++) src_q[1].push_back(9'((i == 5 ? 256 : 0) + 'h10 + i));
        exp_s = '{8'hC1, 8'h10, 8'h11, 8'h12, 8'h13, 8'h81, 8'h14, 8'h15, 8'hC1, 8'h16};
        run_until(8, "burst");
        src_q[1].push_back(9'h116);
        run_until(10, "burst");
        check_stream("burst");

        // ch0 goes quiet mid-packet: released after the timeout, ch1 served, ch0 resumes without SOP
        do_reset();
        src_q[0].push_back(9'h020);
        src_q[0].push_back(9'h021);
        src_q[1].push_back(9'h130);
        exp_s = '{8'hC0, 8'h20, 8'h21, 8'hC1, 8'h30, 8'h80, 8'h22};
        run_until(5, "tmo");
        src_q[0].push_back(9'h122);
        run_until(7, "tmo");
        check_stream("tmo");
        check("tmo_gap", 32'(gap_q.size() > 3 ? gap_q[3] : -1), 32'(IT + 1));

        // reset in the middle of a ch3 burst
        do_reset();
        for (int i = 0; i < 4; i++) src_q[3].push_back(9'((i == 3 ? 256 : 0) + 'h40 + i));
        run_until(3, "rstmid");
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        check("rstmid_valid", 32'(o_valid), 32'd0);
        check("rstmid_data", 32'(o_data), 32'd0);
        check("rstmid_ch_ready", 32'(o_ch_ready), 32'd0);
        out_q.delete();
        exp_s = '{8'hC3, 8'h42, 8'h43};
        run_until(3, "rstmid");
        check_stream("rstmid");

        // randomized traffic with random gaps, long stalls and bridge backpressure
        do_reset();
        model_reset();
        model_on = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int k = 0; k < NCH; k++) begin
                if (src_q[k].size() == 0 && $urandom_range(0, 3) == 0) begin
                    int len;
                    len = $urandom_range(1, 9);
                    for (int b = 0; b < len; b++)
                        src_q[k].push_back({(b == len - 1) ? 1'b1 : 1'b0, 8'($urandom)});
                end
                if (hold[k] > 0) begin
                    hold[k]--;
                    en[k] = 1'b0;
                end else if ($urandom_range(0, 99) == 0) begin
                    hold[k] = $urandom_range(10, 30);
                    en[k]   = 1'b0;
                end else begin
                    en[k] = ($urandom_range(0, 9) != 0);
                end
            end
            step(1'b0, $urandom_range(0, 3) != 0);
        end
        model_on = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
